// File: rtl/bin2dec_seq.sv
// bin2dec_seq: sequential binary-to-BCD converter (shift-and-add-3).
// One conversion at a time: a request is accepted in IDLE, WIDTH shift cycles
// follow, and a single-cycle done pulse accompanies the updated bcd result.
//
// Ports:
//   clk    - clock, all state changes on the rising edge
//   rst_n  - synchronous active-low reset
//   start  - conversion request, honoured only in IDLE
//   bin    - unsigned binary operand, sampled when start is accepted
//   busy   - high while shifting
//   done   - one-cycle pulse, bcd holds a new result
//   bcd    - packed BCD result, ones digit in bcd[3:0]
module bin2dec_seq #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd
);

  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam int unsigned BW = 4 * DIGITS;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]       state,   state_d;
  logic [CW-1:0]    cnt,     cnt_d;
  logic [BW-1:0]    scratch, scratch_d;
  logic [WIDTH-1:0] operand, operand_d;
  logic             busy_d;
  logic             done_d;
  logic [BW-1:0]    bcd_d;
  logic [BW-1:0]    adj;

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      scratch <= '0;
      operand <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      bcd     <= '0;
    end else begin
      state   <= state_d;
      cnt     <= cnt_d;
      scratch <= scratch_d;
      operand <= operand_d;
      busy    <= busy_d;
      done    <= done_d;
      bcd     <= bcd_d;
    end
  end

  // Next-state, datapath and output logic
  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    scratch_d = scratch;
    operand_d = operand;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    bcd_d     = bcd;

    // Per-digit +3 correction so each digit stays in 0..9 after doubling
    adj = scratch;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (scratch[4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
      end
    end

    case (state)
      IDLE: begin
        if (start) begin
          operand_d = bin;
          scratch_d = '0;
          cnt_d     = CW'(WIDTH);
          state_d   = SHIFT;
          busy_d    = 1'b1;
        end
      end
      SHIFT: begin
        {scratch_d, operand_d} = {adj, operand} << 1;
        if (cnt != '0) begin
          cnt_d = cnt - CW'(1);
        end
        // The counter reaches zero on this edge: last shift done
        if (cnt <= CW'(1)) begin
          state_d = DONE;
        end else begin
          busy_d = 1'b1;
        end
      end
      DONE: begin
        bcd_d   = scratch;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_bin2dec_seq.sv
// Self-checking bench for bin2dec_seq: randomized and directed conversions
// compared against an arithmetic decimal-digit model.
module tb_bin2dec_seq;

  localparam int unsigned WIDTH  = 8;
  localparam int unsigned DIGITS = 3;

  logic                clk;
  logic                rst_n;
  logic                start;
  logic [WIDTH-1:0]    bin;
  logic                busy;
  logic                done;
  logic [4*DIGITS-1:0] bcd;

  int total;
  int bad;

  bin2dec_seq #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .bcd   (bcd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  // Reference: decimal digits of v via plain division
  function automatic logic [4*DIGITS-1:0] ref_bcd(input int v);
    logic [4*DIGITS-1:0] r;
    int t;
    r = '0;
    t = v;
    for (int i = 0; i < int'(DIGITS); i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are then sampled 1 time unit after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One conversion of v; optional extra start pulse with another operand
  // at sample index poke_j (must be ignored). bin is scrambled afterwards.
  task automatic run_conv(input logic [WIDTH-1:0] v, input int poke_j,
                          input logic [WIDTH-1:0] poke_v);
    int busy_n;
    int done_n;
    int done_at;
    logic [4*DIGITS-1:0] bcd_at;
    busy_n  = 0;
    done_n  = 0;
    done_at = -1;
    bcd_at  = '0;
    bin   = v;
    start = 1'b1;
    tick();
    for (int j = 0; j < 24; j++) begin
      if (busy) busy_n++;
      if (done) begin
        done_n++;
        if (done_at < 0) begin
          done_at = j;
          bcd_at  = bcd;
        end
      end
      if (j == poke_j) begin
        start = 1'b1;
        bin   = poke_v;
      end else begin
        start = 1'b0;
        bin   = WIDTH'($urandom);
      end
      tick();
    end
    start = 1'b0;
    check($sformatf("busy_cycles[%0d]", v), busy_n, int'(WIDTH));
    check($sformatf("latency[%0d]", v), done_at, int'(WIDTH) + 1);
    check($sformatf("done_count[%0d]", v), done_n, 1);
    check($sformatf("bcd[%0d]", v), int'(bcd_at), int'(ref_bcd(int'(v))));
  endtask

  initial begin
    int seen;
    int last;
    int dn;
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    start = 1'b1;
    bin   = '1;

    // Reset has priority over start
    repeat (3) tick();
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_bcd", int'(bcd), 0);

    // First request accepted on the first edge out of reset
    rst_n = 1'b1;
    run_conv(8'd5, -1, 8'd0);

    // Extremes
    run_conv(8'd255, -1, 8'd0);
    run_conv(8'd0,   -1, 8'd0);
    run_conv(8'd100, -1, 8'd0);

    // Random operands
    for (int k = 0; k < 8; k++) begin
      run_conv(WIDTH'($urandom), -1, 8'd0);
    end

    // Start during SHIFT is ignored
    run_conv(8'd42, 2, 8'd99);

    // Reset in the middle of a conversion
    bin   = 8'd200;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    check("abort_bcd", int'(bcd), 0);
    dn = 0;
    for (int j = 0; j < 15; j++) begin
      if (done) dn++;
      bin = WIDTH'($urandom);
      tick();
    end
    check("abort_no_done", dn, 0);
    run_conv(8'd7, -1, 8'd0);

    // Back-to-back with start held high
    seen  = 0;
    last  = -1;
    bin   = '0;
    start = 1'b1;
    tick();
    for (int cyc = 0; cyc < 2700 && seen < 256; cyc++) begin
      if (done) begin
        check($sformatf("b2b_bcd[%0d]", seen), int'(bcd), int'(ref_bcd(seen)));
        if (seen == 0) check("b2b_first_latency", cyc, int'(WIDTH) + 1);
        else check($sformatf("b2b_spacing[%0d]", seen), cyc - last, int'(WIDTH) + 2);
        last = cyc;
        seen++;
        if (seen < 256) bin = WIDTH'(seen);
        else start = 1'b0;
      end else begin
        bin = WIDTH'($urandom);
      end
      tick();
    end
    start = 1'b0;
    check("b2b_count", seen, 256);
    repeat (12) tick();

    // Result holds while idle with bin toggling
    run_conv(8'd73, -1, 8'd0);
    for (int j = 0; j < 20; j++) begin
      bin = ~bin;
      tick();
      check("hold_bcd", int'(bcd), 'h073);
      check("hold_done", int'(done), 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bin2dec_seq.md
BIN2DEC_SEQ -- requirements
Module: bin2dec_seq

Interface
REQ-001 Parameter WIDTH, default 8, binary input width in bits.
REQ-002 Parameter DIGITS, default 3, number of BCD output digits; SHALL satisfy 10^DIGITS > 2^WIDTH-1.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst_n  input  1  synchronous, active-low reset, sampled on rising edge of clk.
REQ-005 start  input  1  conversion request; sampled only in IDLE.
REQ-006 bin  input  WIDTH  unsigned binary operand; sampled in the cycle start is accepted.
REQ-007 busy  output  1  high while a conversion is in progress (SHIFT state).
REQ-008 done  output  1  single-cycle pulse marking a valid new result on bcd.
REQ-009 bcd  output  4*DIGITS  packed BCD result, ones digit in bcd[3:0], hundreds in bcd[11:8] at defaults.

Function
REQ-010 FSM states SHALL be exactly IDLE, SHIFT and DONE.
REQ-011 IDLE: start=1 -> latch bin into the operand shift register, clear the BCD scratch register, load the bit counter with WIDTH, go to SHIFT; start=0 -> stay in IDLE.
REQ-012 SHIFT: each cycle, digits >= 5 in the scratch register get +3 first; then {scratch, operand} shifts left by one and the counter decrements.
REQ-013 SHIFT -> DONE on the cycle the counter reaches 0, i.e. after exactly WIDTH shift cycles.
REQ-014 DONE: copy the scratch register to bcd, assert done for this one cycle, go to IDLE unconditionally.
REQ-015 Latency: start accepted at edge N -> done high in the cycle after edge N+WIDTH+1 (cycle 9 after acceptance at defaults) -> bcd valid from that cycle.
REQ-016 busy SHALL be 1 in SHIFT only; 0 in IDLE and DONE.
REQ-017 start asserted in SHIFT or DONE SHALL be ignored, with no queueing; changes to bin outside the acceptance cycle SHALL NOT affect the result.
REQ-018 A request accepted in IDLE on the cycle after DONE is legal; back-to-back throughput is one result per WIDTH+2 cycles.
REQ-019 bcd SHALL hold its last value between done pulses; it SHALL NOT update during SHIFT.
REQ-020 Each BCD digit SHALL stay in 0..9 after every shift; the +3 correction applies per digit, independently, before the shift.
REQ-021 Counter width SHALL be ceil(log2(WIDTH+1)) bits; the counter does not wrap, since decrement happens only in SHIFT with counter > 0.
REQ-022 Only one conversion SHALL be in flight at a time; there is no partial or early result output.

Reset
REQ-023 rst_n=0 at a rising edge -> state IDLE, busy=0, done=0, bcd=0, counter=0, scratch and operand registers = 0.
REQ-024 Reset asserted in SHIFT or DONE SHALL abort the conversion with no done pulse; bcd reads 0 on the following cycle.
REQ-025 rst_n has priority over start in the same cycle; start is ignored while rst_n=0.
REQ-026 The first request after reset release SHALL be accepted on the first edge with rst_n=1 and start=1.

Verification
REQ-027 Basic: bin=8'd5, start pulse one cycle -> busy high 8 cycles, done pulse 9 cycles after acceptance, bcd=12'h005.
REQ-028 Extremes: bin=8'd255 -> bcd=12'h255; bin=8'd0 -> bcd=12'h000; bin=8'd100 -> bcd=12'h100; each with exactly one done pulse.
REQ-029 Ignored request: start for bin=8'd42, then start with bin=8'd99 at shift cycle 3 -> single done, bcd=12'h042, no second conversion.
REQ-030 Reset mid-operation: start with bin=8'd200, rst_n=0 at shift cycle 4 for one cycle -> no done, bcd=0, busy=0; new start with bin=8'd7 -> bcd=12'h007.
REQ-031 Back-to-back: start held high continuously with bin stepping 0..255 -> 256 done pulses, each 10 cycles apart, each bcd equal to the decimal digits of the bin sampled at acceptance.
REQ-032 Hold: after the result for bin=8'd73, idle 20 cycles with bin toggling -> bcd stays 12'h073, done stays 0.
